// File: rtl/adder_pkg.sv
// Shared types for the nibble-serial adder.
// Nibble width and sequencing-state encoding.
package adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// All carries computed directly from generate/propagate terms.
module cla4_slice
  import adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             co
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  // lookahead carries; no ripple between bit positions
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[NIB_W-1:0];
    co   = c[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle through a single CLA slice.
// Define OVERFLOW_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = $clog2(NIB);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             co;
  logic             last;

  // select the operand nibbles for the current step
  always_comb begin
    a_nib = a_q[NIB_W*int'(idx_q) +: NIB_W];
    b_nib = b_q[NIB_W*int'(idx_q) +: NIB_W];
    last  = (idx_q == IDX_W'(NIB - 1));
  end

  cla4_slice u_cla (
    .a   (a_nib),
    .b   (b_nib),
    .cin (carry_q),
    .sum (s_nib),
    .co  (co)
  );

  // next-state, datapath updates and handshake outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[NIB_W*int'(idx_q) +: NIB_W] = s_nib;
        carry_d = co;
        if (last) begin
          cout_d  = co;
`ifdef OVERFLOW_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                  & (s_nib[NIB_W-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // handshake and result outputs
  always_comb begin
    in_ready  = (state_q == IDLE) & rst_n;
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
`ifdef OVERFLOW_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: queue-based arithmetic model plus directed cases.
// Define OVERFLOW_EN to also check the ovf output.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVERFLOW_EN
  logic         ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef OVERFLOW_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;
  int cyc         = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           t;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic         c,
                                 input int           t);
    exp_t     e;
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.t  = t;
    return e;
  endfunction

  // single compare process: every falling edge, against the model queue
  always @(negedge clk) begin
    logic ov_exp;
    cyc++;
    if (!rst_n) begin
      q.delete();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, '0);
      check("rst_cout", cout, 1'b0);
`ifdef OVERFLOW_EN
      check("rst_ovf", ovf, 1'b0);
`endif
    end else begin
      check("in_ready", in_ready, q.size() == 0);
      ov_exp = (q.size() != 0) && (cyc >= q[0].t + NIB + 1);
      check("out_valid", out_valid, ov_exp);
      if (out_valid && q.size() != 0) begin
        check("sum", sum, q[0].s);
        check("cout", cout, q[0].co);
`ifdef OVERFLOW_EN
        check("ovf", ovf, q[0].ov);
`endif
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, cyc));
        accepted++;
      end
    end
  end

  // one directed operation; latency counted in edges from presentation
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic c, input logic [W-1:0] es,
                    input logic ec, input logic eo, input int hold);
    int n;
    int lat;
    @(posedge clk); #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_in_ready", in_ready, 1'b1);
    a = x; b = y; cin = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, NIB + 1);
    check("lit_sum", sum, es);
    check("lit_cout", cout, ec);
`ifdef OVERFLOW_EN
    check("lit_ovf", ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected X expectation");
`endif
    repeat (hold) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_sum", sum, es);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drop_out_valid", out_valid, 1'b0);
    check("back_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int n;
    int target;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 10);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);

    // reset while the third nibble is in the slice
    @(posedge clk); #1;
    a = 16'h9999; b = 16'h6767; cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, '0);
    check("mid_rst_cout", cout, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

    // random traffic with valid and ready gaps
    target = accepted + 1000;
    n = 0;
    while (accepted < target && n < 40000) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      n++;
    end
    check("random_ops_done", accepted >= target, 1'b1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 0);
    out_ready = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
